bpu: RTL and testbench
======================

# bpu

Branch prediction and resolution unit for the NPC pipeline, the parametrised successor to the combinational branch-condition logic. It predicts the next fetch PC from a direct-mapped BTB plus a table of 2-bit saturating counters (BHT). It then resolves the real outcome of BRANCH/JAL/JALR in execute, flags mispredictions with a redirect PC, and trains both tables. It sits between IFU (lookup port) and EXU (resolve port).

## Interface
- XLEN, 64, PC/target width
- BHT_DEPTH, 64, number of 2-bit counters; power of 2, ≥2
- BTB_DEPTH, 16, number of BTB entries; power of 2, ≥2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- bp_flush  in  1  invalidate all BTB entries (fence.i); BHT untouched
- if_pc  in  XLEN  fetch PC to predict
- pred_taken  out  1  predicted redirect for if_pc
- pred_target  out  XLEN  predicted next PC (BTB target or if_pc+4)
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  XLEN  PC of execute instruction
- ex_opcode  in  7  opcode
- ex_funct3  in  3  funct3
- ex_smaller  in  1  rs1<rs2, signed/unsigned already chosen upstream per funct3
- ex_equal  in  1  rs1==rs2
- ex_target  in  XLEN  computed target (pc+imm or rs1+imm, LSB cleared for JALR)
- ex_pred_taken  in  1  pred_taken carried down the pipe with this instruction
- ex_pred_target  in  XLEN  pred_target carried down the pipe
- ex_taken  out  1  actual control transfer
- mispredict  out  1  flush younger stages
- redirect_pc  out  XLEN  correct next PC

## Operation
- Indexing: BHT index = pc[log2(BHT_DEPTH)+1:2]; BTB index = pc[log2(BTB_DEPTH)+1:2]; BTB tag = pc[XLEN-1:log2(BTB_DEPTH)+2]; pc[1:0] ignored.
- BTB entry: valid, tag, target[XLEN], is_jump.
- Lookup (combinational from if_pc): hit = valid && tag match. pred_taken = hit && (is_jump || bht[idx][1]). pred_target = pred_taken ? btb target : if_pc+4 (wraps mod 2^XLEN).
- Condition by funct3: 000 equal; 001 ~equal; 100/110 smaller; 101/111 ~smaller; 010/011 → 0.
- ex_taken = ex_valid && (JAL 1101111 || JALR 1100111 || (BRANCH 1100011 && cond)).
- actual_next = ex_taken ? ex_target : ex_pc+4. predicted_next = ex_pred_taken ? ex_pred_target : ex_pc+4.
- mispredict = ex_valid && (actual_next != predicted_next). redirect_pc = actual_next whenever ex_valid, else 0.
- Training at clock edge, only when ex_valid:
  - BRANCH: BHT counter +1 if taken, −1 if not; saturates at 3 and 0.
  - Any taken transfer: write BTB[idx] = {1, tag, ex_target, is_jump = (JAL||JALR)}.
  - Non-control instruction with ex_pred_taken=1 (alias): clear BTB[idx].valid.
  - Not-taken BRANCH: BTB left unchanged (BHT alone suppresses it).

## Timing
- Lookup and resolve outputs are combinational; state updates take effect on the next rising edge.
- Same-cycle lookup and update of the same index: lookup sees the pre-update contents.
- Reset (asynchronous, any time, including mid-update): all BTB valid=0, all BHT counters=2'b01 (weakly not-taken); targets/tags don't care. During and after reset: pred_taken=0, pred_target=if_pc+4.
- bp_flush: clears all valid bits at the edge. A BTB write in the same cycle is dropped; flush wins. BHT training in the same cycle still occurs.
- ex_valid=0: no state change; ex_taken=0, mispredict=0.

## Test plan
- Post-reset lookup if_pc=0x8000_0000 → pred_taken=0, pred_target=0x8000_0004; release, same result.
- BEQ at 0x8000_0010, equal=1, target 0x8000_0100, predicted not-taken → mispredict=1, redirect=0x8000_0100. Next cycle lookup of 0x8000_0010 → pred_taken=1 (counter 2), target 0x8000_0100.
- Repeat the same branch not-taken 3 times → counter 2→1→0→0 (saturates). Lookup → pred_taken=0; the first not-taken resolve gives mispredict=1, redirect=0x8000_0014.
- JALR with ex_target=0x8000_2000, predicted 0x8000_3000 → mispredict=1, redirect=0x8000_2000. BTB is updated with is_jump=1, so the next lookup predicts taken regardless of BHT.
- Alias: ADD (0110011) with ex_pred_taken=1 → mispredict=1, redirect=ex_pc+4, BTB entry invalidated. Separately, bp_flush together with a taken JAL write → entry invalid afterwards.
- Drive rst_n low mid-stream after training → all predictions return to not-taken immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bpu.sv
// ============================================================================
// Module   : bpu
// Purpose  : Branch prediction (BTB + 2-bit BHT) and execute-stage resolution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpu #(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 64,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bp_flush,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_smaller,
  input  logic            ex_equal,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int c_bht_iw = $clog2(BHT_DEPTH);
  localparam int c_btb_iw = $clog2(BTB_DEPTH);
  localparam int c_tag_w  = XLEN - c_btb_iw - 2;

  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  // Only the valid bits and counters carry a reset; tag/target/jump are payload.
  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [BTB_DEPTH-1:0] r_btb_jump;
  logic [c_tag_w-1:0]   r_btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      r_btb_target [BTB_DEPTH];
  logic [1:0]           r_bht        [BHT_DEPTH];

  // ---------------- lookup ----------------
  logic [c_btb_iw-1:0] w_if_btb_idx;
  logic [c_bht_iw-1:0] w_if_bht_idx;
  logic [c_tag_w-1:0]  w_if_tag;
  logic                w_if_hit;

  assign w_if_btb_idx = if_pc[c_btb_iw+1:2];
  assign w_if_bht_idx = if_pc[c_bht_iw+1:2];
  assign w_if_tag     = if_pc[XLEN-1:c_btb_iw+2];
  assign w_if_hit     = r_btb_valid[w_if_btb_idx] && (r_btb_tag[w_if_btb_idx] == w_if_tag);

  assign pred_taken  = w_if_hit && (r_btb_jump[w_if_btb_idx] || r_bht[w_if_bht_idx][1]);
  assign pred_target = pred_taken ? r_btb_target[w_if_btb_idx] : (if_pc + XLEN'(4));

  // ---------------- resolve ----------------
  logic                w_cond;
  logic                w_is_branch;
  logic                w_is_jump;
  logic [XLEN-1:0]     w_ex_pc_plus4;
  logic [XLEN-1:0]     w_actual_next;
  logic [XLEN-1:0]     w_pred_next;
  logic [c_btb_iw-1:0] w_ex_btb_idx;
  logic [c_bht_iw-1:0] w_ex_bht_idx;
  logic                w_btb_wr;
  logic                w_alias_clr;

  always_comb begin
    w_cond = 1'b0;
    case (ex_funct3)
      3'b000:         w_cond = ex_equal;
      3'b001:         w_cond = ~ex_equal;
      3'b100, 3'b110: w_cond = ex_smaller;
      3'b101, 3'b111: w_cond = ~ex_smaller;
      default:        w_cond = 1'b0;
    endcase
  end

  assign w_is_branch   = (ex_opcode == c_op_branch);
  assign w_is_jump     = (ex_opcode == c_op_jal) || (ex_opcode == c_op_jalr);
  assign ex_taken      = ex_valid && (w_is_jump || (w_is_branch && w_cond));

  assign w_ex_pc_plus4 = ex_pc + XLEN'(4);
  assign w_actual_next = ex_taken ? ex_target : w_ex_pc_plus4;
  assign w_pred_next   = ex_pred_taken ? ex_pred_target : w_ex_pc_plus4;
  assign mispredict    = ex_valid && (w_actual_next != w_pred_next);
  assign redirect_pc   = ex_valid ? w_actual_next : '0;

  // ---------------- training ----------------
  assign w_ex_btb_idx = ex_pc[c_btb_iw+1:2];
  assign w_ex_bht_idx = ex_pc[c_bht_iw+1:2];
  assign w_btb_wr     = ex_taken && !bp_flush;
  // A non-control instruction that was predicted taken means a stale/aliased entry.
  assign w_alias_clr  = ex_valid && !w_is_branch && !w_is_jump && ex_pred_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
    end else if (bp_flush) begin
      r_btb_valid <= '0;
    end else if (w_btb_wr) begin
      r_btb_valid[w_ex_btb_idx] <= 1'b1;
    end else if (w_alias_clr) begin
      r_btb_valid[w_ex_btb_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_ex_btb_idx]    <= ex_pc[XLEN-1:c_btb_iw+2];
      r_btb_target[w_ex_btb_idx] <= ex_target;
      r_btb_jump[w_ex_btb_idx]   <= w_is_jump;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (ex_valid && w_is_branch) begin
      if (ex_taken) begin
        if (r_bht[w_ex_bht_idx] != 2'b11) r_bht[w_ex_bht_idx] <= r_bht[w_ex_bht_idx] + 2'd1;
      end else begin
        if (r_bht[w_ex_bht_idx] != 2'b00) r_bht[w_ex_bht_idx] <= r_bht[w_ex_bht_idx] - 2'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bpu.sv
// ============================================================================
// Module   : tb_bpu
// Purpose  : Directed + randomized self-checking bench for bpu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpu;

  localparam int XLEN      = 64;
  localparam int BHT_DEPTH = 64;
  localparam int BTB_DEPTH = 16;
  localparam int TAG_SH    = 2 + $clog2(BTB_DEPTH);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;

  typedef logic [63:0] u64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bp_flush;
  u64         if_pc;
  logic       pred_taken;
  u64         pred_target;
  logic       ex_valid;
  u64         ex_pc;
  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;
  logic       ex_smaller;
  logic       ex_equal;
  u64         ex_target;
  logic       ex_pred_taken;
  u64         ex_pred_target;
  logic       ex_taken;
  logic       mispredict;
  u64         redirect_pc;

  bpu #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .BTB_DEPTH(BTB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bp_flush(bp_flush), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_smaller(ex_smaller), .ex_equal(ex_equal), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed by (pc/4) mod depth.
  bit m_valid [BTB_DEPTH];
  u64 m_tag   [BTB_DEPTH];
  u64 m_tgt   [BTB_DEPTH];
  bit m_jump  [BTB_DEPTH];
  int m_ctr   [BHT_DEPTH];

  function automatic void m_reset();
    for (int i = 0; i < BTB_DEPTH; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < BHT_DEPTH; i++) m_ctr[i] = 1;
  endfunction

  function automatic int btb_i(u64 pc);
    return int'((pc / 4) % BTB_DEPTH);
  endfunction

  function automatic int bht_i(u64 pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  function automatic void m_lookup(input u64 pc, output bit tk, output u64 tg);
    int  i;
    bit  hit;
    i   = btb_i(pc);
    hit = m_valid[i] && (m_tag[i] == (pc >> TAG_SH));
    tk  = hit && (m_jump[i] || m_ctr[bht_i(pc)] >= 2);
    tg  = tk ? m_tgt[i] : pc + 64'd4;
  endfunction

  function automatic bit m_taken();
    bit cond;
    case (ex_funct3)
      3'd0:       cond = ex_equal;
      3'd1:       cond = !ex_equal;
      3'd4, 3'd6: cond = ex_smaller;
      3'd5, 3'd7: cond = !ex_smaller;
      default:    cond = 1'b0;
    endcase
    return ex_valid && (ex_opcode == OP_JAL || ex_opcode == OP_JALR || (ex_opcode == OP_BR && cond));
  endfunction

  function automatic void m_train();
    bit tk;
    int i;
    tk = m_taken();
    i  = btb_i(ex_pc);
    if (ex_valid) begin
      if (ex_opcode == OP_BR) begin
        if (tk) m_ctr[bht_i(ex_pc)] = (m_ctr[bht_i(ex_pc)] == 3) ? 3 : m_ctr[bht_i(ex_pc)] + 1;
        else    m_ctr[bht_i(ex_pc)] = (m_ctr[bht_i(ex_pc)] == 0) ? 0 : m_ctr[bht_i(ex_pc)] - 1;
      end
      if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = ex_pc >> TAG_SH;
        m_tgt[i]   = ex_target;
        m_jump[i]  = (ex_opcode != OP_BR);
      end else if (ex_opcode != OP_BR && ex_opcode != OP_JAL && ex_opcode != OP_JALR && ex_pred_taken) begin
        m_valid[i] = 1'b0;
      end
    end
    if (bp_flush) for (int k = 0; k < BTB_DEPTH; k++) m_valid[k] = 1'b0;
  endfunction

  task automatic chk(input string tag, input u64 obs, input u64 exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit ptk, etk, emp;
    u64 ptg, act, prd;
    m_lookup(if_pc, ptk, ptg);
    etk = m_taken();
    act = etk ? ex_target : ex_pc + 64'd4;
    prd = ex_pred_taken ? ex_pred_target : ex_pc + 64'd4;
    emp = ex_valid && (act != prd);
    chk({tag, ".pred_taken"},  u64'(pred_taken), u64'(ptk));
    chk({tag, ".pred_target"}, pred_target, ptg);
    chk({tag, ".ex_taken"},    u64'(ex_taken), u64'(etk));
    chk({tag, ".mispredict"},  u64'(mispredict), u64'(emp));
    chk({tag, ".redirect"},    redirect_pc, ex_valid ? act : 64'd0);
  endtask

  task automatic set_ex(input bit v, input u64 pc, input logic [6:0] op, input logic [2:0] f3,
                        input bit sm, input bit eq, input u64 tgt, input bit pt, input u64 ptg);
    ex_valid = v; ex_pc = pc; ex_opcode = op; ex_funct3 = f3; ex_smaller = sm;
    ex_equal = eq; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_train();
    #1;
  endtask

  task automatic lookup_only(input string tag, input u64 pc, input bit exp_tk, input u64 exp_tg);
    set_ex(0, 64'h0, OP_ADD, 3'd0, 0, 0, 64'h0, 0, 64'h0);
    if_pc = pc;
    #2;
    check_all(tag);
    chk({tag, ".k_taken"},  u64'(pred_taken), u64'(exp_tk));
    chk({tag, ".k_target"}, pred_target, exp_tg);
    tick();
  endtask

  function automatic u64 rand_pc();
    u64 hi;
    hi = ($urandom_range(0, 3) == 0) ? 64'h0000_0000_4000_0000 : 64'h0000_0000_8000_0000;
    return hi | (u64'($urandom_range(0, 31)) << 2);
  endfunction

  initial begin
    bit ptk;
    u64 ptg;
    logic [6:0] ops [5];
    ops[0] = OP_BR; ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = OP_ADD; ops[4] = OP_LD;

    rst_n = 1'b0;
    bp_flush = 1'b0;
    if_pc = 64'h8000_0000;
    set_ex(0, 64'h0, OP_ADD, 3'd0, 0, 0, 64'h0, 0, 64'h0);
    m_reset();

    // Reset state, held and released
    #2;
    chk("rst.pred_taken",  u64'(pred_taken), 64'd0);
    chk("rst.pred_target", pred_target, 64'h8000_0004);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rel.pred_taken",  u64'(pred_taken), 64'd0);
    chk("rel.pred_target", pred_target, 64'h8000_0004);
    @(posedge clk); #1;

    // Taken BEQ predicted not-taken; same-cycle lookup sees old contents
    if_pc = 64'h8000_0010;
    set_ex(1, 64'h8000_0010, OP_BR, 3'd0, 0, 1, 64'h8000_0100, 0, 64'h8000_0014);
    #2;
    check_all("beq_t");
    chk("beq_t.k_misp",  u64'(mispredict), 64'd1);
    chk("beq_t.k_redir", redirect_pc, 64'h8000_0100);
    chk("beq_t.k_same",  u64'(pred_taken), 64'd0);
    tick();
    lookup_only("beq_lk", 64'h8000_0010, 1, 64'h8000_0100);

    // Three not-taken resolves: counter 2 -> 1 -> 0 -> 0
    for (int k = 0; k < 3; k++) begin
      m_lookup(64'h8000_0010, ptk, ptg);
      if_pc = 64'h8000_0010;
      set_ex(1, 64'h8000_0010, OP_BR, 3'd0, 0, 0, 64'h8000_0100, ptk, ptg);
      #2;
      check_all("beq_nt");
      if (k == 0) begin
        chk("beq_nt.k_misp",  u64'(mispredict), 64'd1);
        chk("beq_nt.k_redir", redirect_pc, 64'h8000_0014);
      end
      tick();
    end
    lookup_only("nt_lk", 64'h8000_0010, 0, 64'h8000_0014);
    // One taken step from a saturated-low counter must stay weakly not-taken
    set_ex(1, 64'h8000_0010, OP_BR, 3'd0, 0, 1, 64'h8000_0100, 0, 64'h8000_0014);
    #2; check_all("sat_t"); tick();
    lookup_only("sat_lk", 64'h8000_0010, 0, 64'h8000_0014);

    // JALR mispredicted target; entry becomes an unconditional jump
    set_ex(1, 64'h8000_0020, OP_JALR, 3'd0, 0, 0, 64'h8000_2000, 1, 64'h8000_3000);
    #2;
    check_all("jalr");
    chk("jalr.k_misp",  u64'(mispredict), 64'd1);
    chk("jalr.k_redir", redirect_pc, 64'h8000_2000);
    tick();
    lookup_only("jalr_lk", 64'h8000_0020, 1, 64'h8000_2000);

    // Alias: ADD predicted taken invalidates the entry
    set_ex(1, 64'h8000_0020, OP_ADD, 3'd0, 1, 1, 64'h1234_5678, 1, 64'h8000_2000);
    #2;
    check_all("alias");
    chk("alias.k_misp",  u64'(mispredict), 64'd1);
    chk("alias.k_redir", redirect_pc, 64'h8000_0024);
    tick();
    lookup_only("alias_lk", 64'h8000_0020, 0, 64'h8000_0024);

    // Flush beats a simultaneous JAL write
    set_ex(1, 64'h8000_0030, OP_JAL, 3'd0, 0, 0, 64'h8000_4000, 0, 64'h8000_0034);
    bp_flush = 1'b1;
    #2; check_all("flush"); tick();
    bp_flush = 1'b0;
    lookup_only("flush_lk", 64'h8000_0030, 0, 64'h8000_0034);

    // PC+4 wraps at the top of the address space
    if_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    set_ex(1, 64'hFFFF_FFFF_FFFF_FFFC, OP_BR, 3'd0, 0, 0, 64'h100, 0, 64'h0);
    #2;
    check_all("wrap");
    chk("wrap.k_redir",  redirect_pc, 64'h0);
    chk("wrap.k_target", pred_target, 64'h0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      u64 pc;
      pc = rand_pc();
      if ($urandom_range(0, 9) < 7) m_lookup(pc, ptk, ptg);
      else begin
        ptk = 1'($urandom_range(0, 1));
        ptg = {32'h0, $urandom} & ~64'h3;
      end
      set_ex(1'($urandom_range(0, 7) != 0), pc, ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom} & ~64'h3, ptk, ptg);
      bp_flush = ($urandom_range(0, 49) == 0);
      if_pc = ($urandom_range(0, 3) == 0) ? pc : rand_pc();
      #2;
      check_all("rnd");
      tick();
    end
    bp_flush = 1'b0;

    // Asynchronous reset mid-stream clears predictions without a clock edge
    set_ex(1, 64'h8000_0040, OP_JAL, 3'd0, 0, 0, 64'h8000_5000, 0, 64'h8000_0044);
    #2; check_all("pre_rst"); tick();
    lookup_only("pre_rst_lk", 64'h8000_0040, 1, 64'h8000_5000);
    if_pc = 64'h8000_0040;
    #1;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.pred_taken",  u64'(pred_taken), 64'd0);
    chk("arst.pred_target", pred_target, 64'h8000_0044);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_all("post_rst");
    chk("post_rst.k_taken", u64'(pred_taken), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
